// File: rtl/wf_gather_ram_reader.sv
// wf_gather_ram_reader: drains the wavefront gather RAM in ring order into a 2-entry
// valid/ready skid buffer and returns one write credit per captured entry.
module wf_gather_ram_reader #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int DW        = 38,
    parameter int OUT_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push_valid,
    output logic          free_pulse,
    output logic          R0_en,
    output logic [AW-1:0] R0_addr,
    input  logic [DW-1:0] R0_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   occupancy,
    output logic          ovf_err
);
    logic [AW:0]   cnt;
    logic [AW-1:0] rd_ptr;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic          head;
    logic          tail;
    logic [DW-1:0] mem [2];
    logic          full;
    logic          pop;
    logic          issue;
    logic          capture;
    logic          accept;

    assign full       = cnt == (AW+1)'(DEPTH);
    assign out_valid  = (buf_cnt != 2'd0) & ~flush;
    assign pop        = out_valid & out_ready;
    // Reads in flight count against buffer space so a stalled consumer never overflows it.
    assign issue      = ~flush & (cnt != '0) &
                        (({1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'(OUT_DEPTH));
    assign capture    = inflight & ~flush;
    assign accept     = push_valid & ~full;
    assign free_pulse = capture;
    assign R0_en      = issue;
    assign R0_addr    = rd_ptr;
    assign out_data   = mem[head];
    assign occupancy  = cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else if (flush) begin
            cnt      <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else begin
            cnt      <= cnt + (AW+1)'(accept) - (AW+1)'(issue);
            inflight <= issue;
            buf_cnt  <= buf_cnt + 2'(capture) - 2'(pop);
            if (issue)
                rd_ptr <= rd_ptr + AW'(1);
            if (capture) begin
                mem[tail] <= R0_data;
                tail      <= ~tail;
            end
            if (pop)
                head <= ~head;
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ovf_err <= 1'b0;
        else if (push_valid & full & ~flush)
            ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_wf_gather_ram_reader.sv
// tb_wf_gather_ram_reader: writer + RAM model around the reader, with a scoreboard
// queue of committed entries checked by a monitor on every output pop.
module tb_wf_gather_ram_reader;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        push_valid;
    logic        free_pulse;
    logic        R0_en;
    logic [3:0]  R0_addr;
    logic [37:0] R0_data;
    logic        out_valid;
    logic        out_ready;
    logic [37:0] out_data;
    logic [4:0]  occupancy;
    logic        ovf_err;

    wf_gather_ram_reader dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .push_valid(push_valid),
        .free_pulse(free_pulse), .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [37:0] ram [16];
    logic [3:0]  wr_ptr;
    logic        wr_en;
    logic [37:0] wr_data;
    int          credits;
    logic [37:0] exp_q [$];
    logic [3:0]  exp_raddr;
    int          occ_m;
    logic        ovf_m;
    int          rd_cnt = 0;
    int          fp_cnt = 0;
    int          pops = 0;
    int          cyc = 0;
    int          pop_times [$];
    logic        prev_stall;
    logic [37:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Writer side and RAM: registered read, one write per committed push.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= 4'd0;
            credits <= 16;
        end else begin
            if (push_valid && wr_en && !flush)
                ram[wr_ptr] <= wr_data;
            if (R0_en)
                R0_data <= ram[R0_addr];
            if (flush) begin
                wr_ptr  <= 4'd0;
                credits <= 16;
            end else begin
                wr_ptr  <= wr_ptr + 4'((push_valid && wr_en) ? 1 : 0);
                credits <= credits - ((push_valid && wr_en) ? 1 : 0) + (free_pulse ? 1 : 0);
            end
        end
    end

    // Monitor: pops against the scoreboard, ring addresses, occupancy and overflow model.
    always @(negedge clock) begin
        if (reset_n) begin
            cyc++;
            if (out_valid && out_ready) begin
                pops++;
                pop_times.push_back(cyc);
                if (exp_q.size() == 0)
                    chk("pop_unexpected", 1, 0);
                else
                    chk("pop_data", out_data, exp_q.pop_front());
            end
            if (R0_en) begin
                chk("raddr", R0_addr, exp_raddr);
                exp_raddr = exp_raddr + 4'd1;
                rd_cnt++;
            end
            if (free_pulse)
                fp_cnt++;
            if (prev_stall && !flush) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            chk("occupancy", occupancy, occ_m);
            chk("ovf_err", ovf_err, ovf_m);
            if (flush) begin
                occ_m = 0;
            end else begin
                if (push_valid && occ_m == 16)
                    ovf_m = 1'b1;
                occ_m = occ_m + ((push_valid && occ_m < 16) ? 1 : 0) - (R0_en ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle(input bit p, input logic [37:0] d, input bit force_push = 1'b0);
        push_valid = p && (credits > 0 || force_push);
        wr_en      = p && credits > 0;
        wr_data    = d;
        if (wr_en)
            exp_q.push_back(d);
        step();
        push_valid = 1'b0;
        wr_en      = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        exp_raddr = 4'd0;
        step();
        flush = 1'b0;
    endtask

    function automatic logic [37:0] rnd();
        return {6'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, fp0, p0;
        bit found;
        reset_n = 1'b0; flush = 1'b0; push_valid = 1'b0; out_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0; exp_raddr = 4'd0; occ_m = 0; ovf_m = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        repeat (2) @(negedge clock);
        chk("rst_outs", {free_pulse, R0_en, out_valid, ovf_err}, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_data", out_data, 0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Single push latency
        cycle(1, 38'h2A00000001);
        @(negedge clock);
        chk("t1_r0en", R0_en, 1);
        chk("t1_addr", R0_addr, 0);
        chk("t1_occ", occupancy, 1);
        step();
        @(negedge clock);
        chk("t2_free", free_pulse, 1);
        chk("t2_occ", occupancy, 0);
        chk("t2_valid", out_valid, 0);
        step();
        @(negedge clock);
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, 38'h2A00000001);
        step();

        // Back-to-back throughput
        do_flush();
        pop_times.delete();
        fp0 = fp_cnt;
        for (int i = 0; i < 16; i++) cycle(1, rnd());
        repeat (6) step();
        chk("b2b_pops", pop_times.size(), 16);
        chk("b2b_span", pop_times[15] - pop_times[0], 15);
        chk("b2b_free", fp_cnt - fp0, 16);

        // Backpressure
        do_flush();
        out_ready = 1'b0;
        rd0 = rd_cnt;
        p0 = pops;
        for (int i = 0; i < 5; i++) cycle(1, rnd());
        repeat (4) step();
        @(negedge clock);
        chk("bp_reads", rd_cnt - rd0, 2);
        chk("bp_occ", occupancy, 3);
        chk("bp_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        repeat (10) step();
        chk("bp_drain", pops - p0, 5);
        chk("bp_empty", exp_q.size(), 0);

        // Ring wrap
        do_flush();
        rd0 = rd_cnt;
        for (int i = 0; i < 20; i++) cycle(1, rnd());
        repeat (6) step();
        chk("wrap_reads", rd_cnt - rd0, 20);
        chk("wrap_empty", exp_q.size(), 0);

        // Overflow
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) cycle(1, rnd());
        repeat (3) step();
        @(negedge clock);
        chk("ovf_full", occupancy, 16);
        chk("ovf_pre", ovf_err, 0);
        step();
        cycle(1, rnd(), 1'b1);
        @(negedge clock);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_held", occupancy, 16);
        step();
        do_flush();
        @(negedge clock);
        chk("ovf_sticky", ovf_err, 1);
        step();

        // Flush with a read in flight and the buffer occupied
        do_flush();
        out_ready = 1'b0;
        cycle(1, rnd());
        cycle(1, rnd());
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (free_pulse && out_valid) found = 1'b1;
            else step();
        end
        chk("fl_reached", found, 1);
        fp0 = fp_cnt;
        flush = 1'b1;
        exp_q.delete();
        exp_raddr = 4'd0;
        @(negedge clock);
        chk("fl_cycle", {free_pulse, out_valid, R0_en}, 0);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("fl_after", {free_pulse, out_valid}, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_nofree", fp_cnt - fp0, 0);
        step();
        out_ready = 1'b1;
        cycle(1, rnd());
        repeat (5) step();
        chk("fl_repush", exp_q.size(), 0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 99) == 0) do_flush();
            else cycle($urandom_range(0, 9) < 6, rnd());
        end
        out_ready = 1'b1;
        repeat (25) step();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_occ", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
